// File: rtl/hood_pkg.sv
// Shared types and constants for the kitchen-hood fan-mode controller.
// Covers the FSM state encoding, mode codes, default durations and width helpers.
package hood_pkg;

    typedef enum logic [2:0] {
        ST_STANDBY    = 3'd0,
        ST_MENU       = 3'd1,
        ST_LEVEL      = 3'd2,
        ST_TURBO      = 3'd3,
        ST_TURBO_EXIT = 3'd4,
        ST_CLEAN      = 3'd5
    } hood_state_e;

    localparam int STANDBY_CODE  = 0;

    localparam int DEF_TICK_DIV  = 100_000_000;
    localparam int DEF_TURBO_SEC = 60;
    localparam int DEF_EXIT_SEC  = 60;
    localparam int DEF_CLEAN_SEC = 180;

    // Self-clean sits just above the top (turbo) speed.
    function automatic int clean_code(input int num_levels);
        return num_levels + 1;
    endfunction

    function automatic int mode_width(input int num_levels);
        return $clog2(num_levels + 2);
    endfunction

endpackage

// File: rtl/hood_sec_timer.sv
// Seconds countdown: a prescaler dividing clk to a one-second tick and a down-counter.
// The prescaler only runs while a count is pending and restarts on every load.
module hood_sec_timer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [SW-1:0] load_val,
    input  logic          clear,
    output logic          tick,
    output logic          expire,
    output logic [SW-1:0] remain
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_remain;
    logic          w_running;

    assign w_running = (r_remain != '0);
    assign tick      = w_running && (r_pre == PW'(TICK_DIV - 1));
    assign expire    = tick && (r_remain == SW'(1));
    assign remain    = r_remain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre    <= '0;
            r_remain <= '0;
        end else if (clear) begin
            r_pre    <= '0;
            r_remain <= '0;
        end else if (load) begin
            r_pre    <= '0;
            r_remain <= load_val;
        end else if (tick) begin
            r_pre    <= '0;
            r_remain <= r_remain - SW'(1);
        end else if (w_running) begin
            r_pre    <= r_pre + PW'(1);
        end
    end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Kitchen-hood fan-mode FSM: standby / menu / speeds / timed turbo / self-clean.
// Outputs decode from registered state; timed states share one seconds timer.
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int TURBO_SEC  = DEF_TURBO_SEC,
    parameter int EXIT_SEC   = DEF_EXIT_SEC,
    parameter int CLEAN_SEC  = DEF_CLEAN_SEC,
    parameter int SW         = 16,
    localparam int MW        = mode_width(NUM_LEVELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power_on,
    input  logic                  menu_pulse,
    input  logic [NUM_LEVELS-1:0] level_pulse,
    input  logic                  clean_pulse,
    output logic [MW-1:0]         mode_state,
    output logic [NUM_LEVELS-1:0] level_led,
    output logic                  menu_led,
    output logic                  clean_led,
    output logic [SW-1:0]         remain_sec,
    output logic                  turbo_used,
    output logic                  done_pulse
);

    if (NUM_LEVELS < 2) begin : g_bad_levels
        $error("hood_mode_ctrl: NUM_LEVELS must be at least 2");
    end
    if (TURBO_SEC < 1 || EXIT_SEC < 1 || CLEAN_SEC < 1 ||
        (TURBO_SEC >> SW) != 0 || (EXIT_SEC >> SW) != 0 || (CLEAN_SEC >> SW) != 0) begin : g_bad_dur
        $error("hood_mode_ctrl: durations must be 1..2**SW-1");
    end

    hood_state_e   r_state, w_next_state;
    logic [MW-1:0] r_level, w_next_level;
    logic          r_turbo_used, r_done;
    logic          w_load, w_set_turbo, w_clear;
    logic [SW-1:0] w_load_val, w_remain;
    logic          w_tick, w_expire, w_timeout;
    logic [MW-1:0] w_lvl_num;
    logic          w_lvl_low;

    assign w_clear   = !power_on;
    assign w_timeout = w_tick && w_expire;

    hood_sec_timer #(.TICK_DIV(TICK_DIV), .SW(SW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .clear    (w_clear),
        .tick     (w_tick),
        .expire   (w_expire),
        .remain   (w_remain)
    );

    // Lowest pressed bit wins; w_lvl_low means it is an ordinary (non-turbo) speed.
    always_comb begin
        w_lvl_num = '0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (level_pulse[i]) w_lvl_num = MW'(i + 1);
        end
        w_lvl_low = (|level_pulse) && (w_lvl_num != MW'(NUM_LEVELS));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_STANDBY;
            r_level <= '0;
        end else begin
            r_state <= w_next_state;
            r_level <= w_next_level;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_turbo_used <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= power_on && (r_state == ST_CLEAN) && w_timeout;
            if (!power_on)       r_turbo_used <= 1'b0;
            else if (w_set_turbo) r_turbo_used <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_set_turbo  = 1'b0;
        if (!power_on) begin
            w_next_state = ST_STANDBY;
            w_next_level = '0;
        end else begin
            case (r_state)
                ST_STANDBY: begin
                    if (menu_pulse) w_next_state = ST_MENU;
                end
                ST_MENU: begin
                    if (menu_pulse) begin
                        w_next_state = ST_STANDBY;
                    end else if (clean_pulse) begin
                        w_next_state = ST_CLEAN;
                        w_load       = 1'b1;
                        w_load_val   = SW'(CLEAN_SEC);
                    end else if (w_lvl_low) begin
                        w_next_state = ST_LEVEL;
                        w_next_level = w_lvl_num;
                    end else if (level_pulse[NUM_LEVELS-1] && !r_turbo_used) begin
                        w_next_state = ST_TURBO;
                        w_load       = 1'b1;
                        w_load_val   = SW'(TURBO_SEC);
                        w_set_turbo  = 1'b1;
                    end
                end
                ST_LEVEL: begin
                    if (menu_pulse) begin
                        w_next_state = ST_STANDBY;
                        w_next_level = '0;
                    end else if (w_lvl_low) begin
                        w_next_level = w_lvl_num;
                    end
                end
                ST_TURBO: begin
                    if (menu_pulse) begin
                        w_next_state = ST_TURBO_EXIT;
                        w_load       = 1'b1;
                        w_load_val   = SW'(EXIT_SEC);
                    end else if (w_timeout) begin
                        w_next_state = ST_LEVEL;
                        w_next_level = MW'(NUM_LEVELS - 1);
                    end
                end
                ST_TURBO_EXIT, ST_CLEAN: begin
                    if (w_timeout) w_next_state = ST_STANDBY;
                end
                default: w_next_state = ST_STANDBY;
            endcase
        end
    end

    always_comb begin
        mode_state = MW'(STANDBY_CODE);
        level_led  = '0;
        menu_led   = 1'b0;
        clean_led  = 1'b0;
        case (r_state)
            ST_MENU: menu_led = 1'b1;
            ST_LEVEL: begin
                mode_state = r_level;
                level_led  = NUM_LEVELS'(1) << (r_level - MW'(1));
            end
            ST_TURBO, ST_TURBO_EXIT: begin
                mode_state                = MW'(NUM_LEVELS);
                level_led[NUM_LEVELS-1]   = 1'b1;
            end
            ST_CLEAN: begin
                mode_state = MW'(clean_code(NUM_LEVELS));
                clean_led  = 1'b1;
            end
            default: ;
        endcase
    end

    assign remain_sec = w_remain;
    assign turbo_used = r_turbo_used;
    assign done_pulse = r_done;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Bench for hood_mode_ctrl with short durations: speed select, turbo drop/exit,
// self-clean, pulse priorities, power-off abort and mid-countdown reset.
module tb_hood_mode_ctrl;

    localparam int NL = 3;
    localparam int TD = 4;
    localparam int EW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          power_on;
    logic          menu_pulse;
    logic [NL-1:0] level_pulse;
    logic          clean_pulse;
    logic [2:0]    mode_state;
    logic [NL-1:0] level_led;
    logic          menu_led;
    logic          clean_led;
    logic [15:0]   remain_sec;
    logic          turbo_used;
    logic          done_pulse;
    logic [EW-1:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    hood_mode_ctrl #(
        .NUM_LEVELS(NL), .TICK_DIV(TD), .TURBO_SEC(3), .EXIT_SEC(2),
        .CLEAN_SEC(5), .SW(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .power_on    (power_on),
        .menu_pulse  (menu_pulse),
        .level_pulse (level_pulse),
        .clean_pulse (clean_pulse),
        .mode_state  (mode_state),
        .level_led   (level_led),
        .menu_led    (menu_led),
        .clean_led   (clean_led),
        .remain_sec  (remain_sec),
        .turbo_used  (turbo_used),
        .done_pulse  (done_pulse)
    );

    always #5 clk = ~clk;

    assign w_obs = {mode_state, level_led, menu_led, clean_led, remain_sec, turbo_used, done_pulse};

    function automatic logic [EW-1:0] e(input int mode, input logic [2:0] led, input logic ml,
                                        input logic cl, input int rem, input logic tu, input logic dn);
        return {3'(mode), led, ml, cl, 16'(rem), tu, dn};
    endfunction

    task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs mode=%0d led=%b m=%b c=%b rem=%0d tu=%b dn=%b exp mode=%0d led=%b m=%b c=%b rem=%0d tu=%b dn=%b",
                     tag, obs[25:23], obs[22:20], obs[19], obs[18], obs[17:2], obs[1], obs[0],
                     exp[25:23], exp[22:20], exp[19], exp[18], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of pulses, queue the expected post-edge outputs, compare after the edge.
    task automatic step(input logic m, input logic [2:0] l, input logic c, input string tag,
                        input logic [EW-1:0] exp);
        menu_pulse  = m;
        level_pulse = l;
        clean_pulse = c;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        menu_pulse  = 1'b0;
        level_pulse = '0;
        clean_pulse = 1'b0;
        check_eq(tag, w_obs, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b0; power_on = 1'b0;
        menu_pulse = 1'b0; level_pulse = '0; clean_pulse = 1'b0;
        @(posedge clk); #1;
        step(1, 3'b111, 1, "reset", e(0, 3'b000, 0, 0, 0, 0, 0));
        rst = 1'b1; power_on = 1'b1;

        // Normal speed select and standby ignoring non-menu pulses
        step(0, 3'b001, 1, "stby_ignore", e(0, 3'b000, 0, 0, 0, 0, 0));
        step(1, 3'b000, 0, "menu_in",     e(0, 3'b000, 1, 0, 0, 0, 0));
        step(0, 3'b001, 0, "lvl1",        e(1, 3'b001, 0, 0, 0, 0, 0));
        step(0, 3'b010, 0, "lvl2",        e(2, 3'b010, 0, 0, 0, 0, 0));
        step(0, 3'b100, 1, "lvl_top_cln", e(2, 3'b010, 0, 0, 0, 0, 0));
        step(1, 3'b000, 0, "lvl_menu",    e(0, 3'b000, 0, 0, 0, 0, 0));

        // Turbo auto-drop after 3 s
        step(1, 3'b000, 0, "t_menu", e(0, 3'b000, 1, 0, 0, 0, 0));
        step(0, 3'b100, 0, "t_in",   e(3, 3'b100, 0, 0, 3, 1, 0));
        for (int j = 1; j < 12; j++)
            step(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $sformatf("t_run%0d", j), e(3, 3'b100, 0, 0, 3 - j / TD, 1, 0));
        step(0, 3'b000, 0, "t_drop",  e(2, 3'b010, 0, 0, 0, 1, 0));
        step(1, 3'b000, 0, "t_stby",  e(0, 3'b000, 0, 0, 0, 1, 0));
        step(1, 3'b000, 0, "t_menu2", e(0, 3'b000, 1, 0, 0, 1, 0));
        step(0, 3'b100, 0, "t_used",  e(0, 3'b000, 1, 0, 0, 1, 0));
        step(1, 3'b000, 0, "t_stby2", e(0, 3'b000, 0, 0, 0, 1, 0));

        // Power cycle clears turbo_used, then turbo early exit
        power_on = 1'b0;
        step(1, 3'b000, 0, "pwr_off", e(0, 3'b000, 0, 0, 0, 0, 0));
        power_on = 1'b1;
        step(1, 3'b000, 0, "x_menu", e(0, 3'b000, 1, 0, 0, 0, 0));
        step(0, 3'b100, 0, "x_in",   e(3, 3'b100, 0, 0, 3, 1, 0));
        step(0, 3'b000, 0, "x_run",  e(3, 3'b100, 0, 0, 3, 1, 0));
        step(1, 3'b000, 0, "x_exit", e(3, 3'b100, 0, 0, 2, 1, 0));
        for (int j = 1; j < 8; j++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $sformatf("x_run%0d", j), e(3, 3'b100, 0, 0, 2 - j / TD, 1, 0));
        step(0, 3'b000, 0, "x_done", e(0, 3'b000, 0, 0, 0, 1, 0));

        // Self-clean, all pulses ignored, single-cycle done
        step(1, 3'b000, 0, "c_menu", e(0, 3'b000, 1, 0, 0, 1, 0));
        step(0, 3'b000, 1, "c_in",   e(4, 3'b000, 0, 1, 5, 1, 0));
        for (int j = 1; j < 20; j++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $sformatf("c_run%0d", j), e(4, 3'b000, 0, 1, 5 - j / TD, 1, 0));
        step(0, 3'b000, 0, "c_done",  e(0, 3'b000, 0, 0, 0, 1, 1));
        step(0, 3'b000, 0, "c_after", e(0, 3'b000, 0, 0, 0, 1, 0));

        // Priorities
        step(1, 3'b000, 0, "p_menu",   e(0, 3'b000, 1, 0, 0, 1, 0));
        step(1, 3'b000, 1, "p_m_c",    e(0, 3'b000, 0, 0, 0, 1, 0));
        step(1, 3'b000, 0, "p_menu2",  e(0, 3'b000, 1, 0, 0, 1, 0));
        step(0, 3'b011, 0, "p_011",    e(1, 3'b001, 0, 0, 0, 1, 0));
        step(0, 3'b110, 0, "p_110",    e(2, 3'b010, 0, 0, 0, 1, 0));
        step(1, 3'b001, 1, "p_lvl_m",  e(0, 3'b000, 0, 0, 0, 1, 0));
        step(1, 3'b000, 0, "p_menu3",  e(0, 3'b000, 1, 0, 0, 1, 0));
        step(0, 3'b001, 1, "p_c_lvl",  e(4, 3'b000, 0, 1, 5, 1, 0));
        for (int j = 1; j < 7; j++)
            step(0, 3'b000, 0, $sformatf("a_run%0d", j), e(4, 3'b000, 0, 1, 5 - j / TD, 1, 0));

        // Power-off abort mid-clean
        power_on = 1'b0;
        step(1, 3'b000, 0, "a_off",  e(0, 3'b000, 0, 0, 0, 0, 0));
        step(0, 3'b000, 0, "a_off2", e(0, 3'b000, 0, 0, 0, 0, 0));
        power_on = 1'b1;

        // Reset mid-turbo
        step(1, 3'b000, 0, "r_menu", e(0, 3'b000, 1, 0, 0, 0, 0));
        step(0, 3'b100, 0, "r_in",   e(3, 3'b100, 0, 0, 3, 1, 0));
        step(0, 3'b000, 0, "r_run1", e(3, 3'b100, 0, 0, 3, 1, 0));
        step(0, 3'b000, 0, "r_run2", e(3, 3'b100, 0, 0, 3, 1, 0));
        rst = 1'b0;
        step(0, 3'b000, 0, "r_rst",  e(0, 3'b000, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step(0, 3'b000, 0, "r_idle", e(0, 3'b000, 0, 0, 0, 0, 0));
        step(1, 3'b000, 0, "r_menu2", e(0, 3'b000, 1, 0, 0, 0, 0));
        step(0, 3'b100, 0, "r_turbo", e(3, 3'b100, 0, 0, 3, 1, 0));

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain obs=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Parametrised fan-mode controller for the kitchen-hood design; the next generation of the fixed three-speed mode selector. It takes debounced single-cycle button pulses and the power state from the on/off controller, and runs the standby / menu / N-speed / timed-turbo / self-clean state machine. Internal second timers drive auto-return and countdowns. It publishes the mode code, LED drive, and remaining seconds for the tube display.

## Interface
Parameters:
- NUM_LEVELS, 3, number of fan speeds. The top speed is the timed turbo ("hurricane") speed. Minimum 2.
- TICK_DIV, 100_000_000, clk cycles per second.
- TURBO_SEC, 60, turbo run time before auto-drop to speed NUM_LEVELS-1.
- EXIT_SEC, 60, run-on time after menu is pressed in turbo, before standby.
- CLEAN_SEC, 180, self-clean duration.
- SW, 16, width of the remaining-seconds output.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-low reset.
- power_on  in  1  machine_state from the on/off controller; 0 means powered off.
- menu_pulse  in  1  one-cycle menu press.
- level_pulse  in  NUM_LEVELS  one-cycle speed presses; bit i selects speed i+1.
- clean_pulse  in  1  one-cycle self-clean press.
- mode_state  out  MW=$clog2(NUM_LEVELS+2)  0 = standby, 1..NUM_LEVELS = speed, NUM_LEVELS+1 = self-clean.
- level_led  out  NUM_LEVELS  one-hot current speed; all zero otherwise.
- menu_led  out  1  high in MENU.
- clean_led  out  1  high in CLEAN.
- remain_sec  out  SW  seconds left in TURBO, TURBO_EXIT or CLEAN; 0 in all other states.
- turbo_used  out  1  turbo has been entered since the last power-up.
- done_pulse  out  1  one-cycle pulse when self-clean completes.

## Operation
- States: STANDBY, MENU, LEVEL(k) for k in 1..NUM_LEVELS-1, TURBO, TURBO_EXIT, CLEAN.
- mode_state is NUM_LEVELS in both TURBO and TURBO_EXIT.
- If power_on=0, the block is forced to STANDBY from any state; turbo_used clears and the timer clears. This overrides every pulse.
- STANDBY:
  - menu → MENU.
  - Every other pulse is ignored.
- MENU:
  - menu → STANDBY.
  - level_pulse[i] with i<NUM_LEVELS-1 → LEVEL(i+1).
  - Top bit → TURBO, only if turbo_used=0; otherwise the press is ignored.
  - clean → CLEAN.
- LEVEL(k):
  - Lower level_pulse bits switch speed directly.
  - Top bit and clean are ignored.
  - menu → STANDBY.
- TURBO:
  - On entry: set turbo_used and load TURBO_SEC.
  - On expiry → LEVEL(NUM_LEVELS-1).
  - menu → TURBO_EXIT; load EXIT_SEC.
  - Level and clean pulses are ignored.
- TURBO_EXIT:
  - On expiry → STANDBY.
  - All pulses are ignored.
- CLEAN:
  - On entry: load CLEAN_SEC.
  - On expiry → STANDBY and assert done_pulse.
  - All pulses, including menu, are ignored.
- Simultaneous pulses, in priority order:
  - menu beats clean, and clean beats level.
  - Among level bits, the lowest index wins.
- Timer:
  - The prescaler counts 0..TICK_DIV-1 and ticks on TICK_DIV-1.
  - The prescaler clears on every timed-state entry, so the first second is full length.
  - remain_sec decrements on each tick.
  - Expiry is a tick while remain_sec==1. A timed state therefore lasts exactly duration×TICK_DIV cycles.
- No wrap-around: remain_sec never goes below 0. Durations must fit in SW bits; this is checked at elaboration.

## Timing
- Reset (rst=0 at a clk edge):
  - State = STANDBY.
  - All outputs are 0, including turbo_used and the prescaler.
- All outputs are registered. A pulse sampled in cycle n is reflected in the outputs in cycle n+1.
- remain_sec shows the loaded duration in the first cycle of a timed state.
- On expiry the new state and remain_sec=0 appear one cycle after the expiring tick. done_pulse is high in that same cycle only.
- A power_on fall is reflected in cycle n+1, regardless of timer phase.
- A reset in mid-countdown aborts it with no done_pulse.

## Structure
- Shared package hood_pkg contains:
  - The state enum.
  - The mode-code constants STANDBY_CODE=0 and a clean-code function of NUM_LEVELS.
  - Default durations.
  - The MW width helper.
- Sub-module hood_sec_timer contains the prescaler and the SW-bit down-counter. Its interface is load, load_val, clear, tick, expire and remain.

## Test plan
- Bench parameters: TICK_DIV=4, TURBO_SEC=3, EXIT_SEC=2, CLEAN_SEC=5, NUM_LEVELS=3.
- Normal speed select: reset, power_on=1, menu, level_pulse=001 → mode_state=1, level_led=001. Then level_pulse=010 → mode_state=2. Then menu → mode_state=0.
- Turbo auto-drop: menu, level_pulse=100 → mode_state=3 and remain_sec=3. After exactly 12 cycles → mode_state=2, remain_sec=0, turbo_used=1. Then menu, menu, level_pulse=100 → stays in MENU (menu_led=1).
- Turbo early exit: in TURBO press menu → mode_state stays 3 with remain_sec=2. After 8 cycles → mode_state=0.
- Self-clean: menu, clean → mode_state=4, clean_led=1. A menu press during CLEAN is ignored. After 20 cycles → mode_state=0 with a single-cycle done_pulse.
- Priorities and abort:
  - In MENU, menu+clean in the same cycle → STANDBY.
  - level_pulse=011 → mode_state=1.
  - Dropping power_on mid-CLEAN → mode_state=0 next cycle, no done_pulse, turbo_used=0.
  - rst=0 mid-TURBO → all outputs 0.
